// File: rtl/conv3x3_scan.sv
// 3x3 raster-scan convolution: 9-tap neighbourhood fetch, signed MAC, arithmetic-shift normalise.
// Define CONV_SAT_EN to clamp results to [0, 2^DATA_W-1]; otherwise results wrap modulo 2^DATA_W.
module conv3x3_scan #(
  parameter int IMG_W  = 50,
  parameter int IMG_H  = 50,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 14,
  parameter int SHIFT  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              coef_wr,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready
);
  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int KDEF [0:8] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  logic [2:0]                    r_state;
  logic [RW-1:0]                 r_row;
  logic [CW-1:0]                 r_col;
  logic [ADDR_W-1:0]             r_pix;
  logic [3:0]                    r_tap;
  logic [1:0]                    r_tr;
  logic [1:0]                    r_tc;
  logic [DW-1:0]                 r_dcnt;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [COEF_W-1:0]      r_kern [0:8];
  logic [RD_LAT-1:0]             r_tv_pipe;
  logic [RD_LAT-1:0][3:0]        r_ti_pipe;

  logic                          w_row_ok;
  logic                          w_col_ok;
  logic                          w_issue;
  logic [ADDR_W-1:0]             w_off;
  logic signed [COEF_W-1:0]      w_coef;
  logic signed [PROD_W-1:0]      w_pix_x;
  logic signed [PROD_W-1:0]      w_coef_x;
  logic signed [PROD_W-1:0]      w_prod;
  logic                          w_last_col;
  logic                          w_last_pix;
  logic [DATA_W-1:0]             w_out;

  // Border taps are suppressed here; they never reach the accumulator.
  assign w_row_ok = !((r_tr == 2'd0) && (r_row == '0)) &&
                    !((r_tr == 2'd2) && (r_row == RW'(IMG_H - 1)));
  assign w_col_ok = !((r_tc == 2'd0) && (r_col == '0)) &&
                    !((r_tc == 2'd2) && (r_col == CW'(IMG_W - 1)));
  assign w_issue  = (r_state == S_FETCH) && w_row_ok && w_col_ok;

  // Neighbour offset relative to the centre pixel, two's complement in ADDR_W bits.
  always_comb begin
    w_off = '0;
    case (r_tap)
      4'd0:    w_off = ADDR_W'(-IMG_W - 1);
      4'd1:    w_off = ADDR_W'(-IMG_W);
      4'd2:    w_off = ADDR_W'(-IMG_W + 1);
      4'd3:    w_off = ADDR_W'(-1);
      4'd5:    w_off = ADDR_W'(1);
      4'd6:    w_off = ADDR_W'(IMG_W - 1);
      4'd7:    w_off = ADDR_W'(IMG_W);
      4'd8:    w_off = ADDR_W'(IMG_W + 1);
      default: w_off = '0;
    endcase
  end

  assign rd_en   = w_issue;
  assign rd_addr = w_issue ? (r_pix + w_off) : '0;

  assign w_coef   = r_kern[r_ti_pipe[RD_LAT-1]];
  assign w_pix_x  = {{(COEF_W + 1){1'b0}}, rd_data};
  assign w_coef_x = {{(DATA_W + 1){w_coef[COEF_W-1]}}, w_coef};
  assign w_prod   = w_pix_x * w_coef_x;

`ifdef CONV_SAT_EN
  logic signed [ACC_W-1:0] w_res;
  assign w_res = r_acc >>> SHIFT;
  always_comb begin
    if (w_res[ACC_W-1])
      w_out = '0;
    else if (|w_res[ACC_W-2:DATA_W])
      w_out = '1;
    else
      w_out = w_res[DATA_W-1:0];
  end
`else
  // Low bits of an arithmetic shift are just a slice of the accumulator.
  assign w_out = r_acc[SHIFT +: DATA_W];
`endif

  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_pix = w_last_col && (r_row == RW'(IMG_H - 1));

  assign busy    = (r_state == S_FETCH) || (r_state == S_DRAIN) || (r_state == S_WRITE);
  assign done    = (r_state == S_FIN);
  assign wr_en   = (r_state == S_WRITE);
  assign wr_addr = wr_en ? r_pix : '0;
  assign wr_data = wr_en ? w_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_pix     <= '0;
      r_tap     <= '0;
      r_tr      <= '0;
      r_tc      <= '0;
      r_dcnt    <= '0;
      r_acc     <= '0;
      r_tv_pipe <= '0;
      r_ti_pipe <= '0;
      for (int i = 0; i < 9; i++) r_kern[i] <= COEF_W'(KDEF[i]);
    end else begin
      // Tap-valid/index pipe lines each coefficient up with its returning pixel.
      r_tv_pipe[0] <= w_issue;
      r_ti_pipe[0] <= r_tap;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tv_pipe[i] <= r_tv_pipe[i-1];
        r_ti_pipe[i] <= r_ti_pipe[i-1];
      end
      if (r_tv_pipe[RD_LAT-1])
        r_acc <= r_acc + {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

      case (r_state)
        S_IDLE: begin
          if (coef_wr && (coef_idx < 4'd9))
            r_kern[coef_idx] <= coef_data;
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_pix   <= '0;
            r_tap   <= '0;
            r_tr    <= '0;
            r_tc    <= '0;
            r_acc   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_tap == 4'd8) begin
            r_tap   <= '0;
            r_tr    <= '0;
            r_tc    <= '0;
            r_dcnt  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_tap <= r_tap + 4'd1;
            if (r_tc == 2'd2) begin
              r_tc <= '0;
              r_tr <= r_tr + 2'd1;
            end else begin
              r_tc <= r_tc + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DW'(1);
          if (r_dcnt == DW'(RD_LAT - 1))
            r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ready) begin
            r_acc <= '0;
            r_pix <= r_pix + ADDR_W'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            r_state <= w_last_pix ? S_FIN : S_FETCH;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_scan.sv
// Scoreboard bench for conv3x3_scan: directed frames, expected writes queued at issue, popped by a monitor.
module tb_conv3x3_scan;
  localparam int W    = 50;
  localparam int H    = 50;
  localparam int NPIX = W * H;
`ifdef CONV_SAT_EN
  localparam int LAP_NB = 0;
`else
  localparam int LAP_NB = 240;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, rd_en, wr_en;
  logic [13:0] rd_addr, wr_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        coef_wr = 1'b0;
  logic [3:0]  coef_idx = 4'd0;
  logic [7:0]  coef_data = 8'd0;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b1;

  always #5 clk = ~clk;

  conv3x3_scan #(
    .IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .ADDR_W(14), .SHIFT(4), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  logic [7:0] img [0:NPIX-1];
  int         kern [0:8];

  // Source memory, one cycle read latency.
  always @(posedge clk)
    if (rd_en) rd_data <= (int'(rd_addr) < NPIX) ? img[rd_addr] : 8'h00;

  typedef struct packed {
    logic [13:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0, n_acc = 0, n_done = 0, frame_id = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int model(input int r, input int c);
    int acc, res, rr, cc;
    acc = 0;
    for (int tr = 0; tr < 3; tr++)
      for (int tc = 0; tc < 3; tc++) begin
        rr = r + tr - 1;
        cc = c + tc - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          acc += int'(img[rr*W + cc]) * kern[tr*3 + tc];
      end
    res = acc >>> 4;
`ifdef CONV_SAT_EN
    if (res < 0) res = 0;
    else if (res > 255) res = 255;
`else
    res = res & 255;
`endif
    return res;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int p = 0; p < NPIX; p++) begin
      e.a = 14'(p);
      e.d = 8'(model(p / W, p % W));
      q.push_back(e);
    end
  endtask

  // Monitor: pops on every accepted write, and checks hold-stability during stalls.
  exp_t       mon_e;
  logic       stall_prev = 1'b0;
  logic [13:0] hold_a;
  logic [7:0]  hold_d;
  always @(negedge clk) begin
    if (done) n_done++;
    if (!rst && wr_en) begin
      if (stall_prev) begin
        chk("hold_addr", int'(wr_addr), int'(hold_a));
        chk("hold_data", int'(wr_data), int'(hold_d));
      end
      if (wr_ready) begin
        if (q.size() == 0) chk("extra_write", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(mon_e.a));
          chk("wr_data", int'(wr_data), int'(mon_e.d));
        end
        case (frame_id)
          0: begin
            if (wr_addr == 14'd0)  chk("A_corner_0_0", int'(wr_data), 9);
            if (wr_addr == 14'd5)  chk("A_edge_0_5", int'(wr_data), 12);
            if (wr_addr == 14'd51) chk("A_interior_1_1", int'(wr_data), 16);
          end
          1: begin
            if (wr_addr == 14'd510) chk("B_lap_10_10", int'(wr_data), 127);
            if (wr_addr == 14'd511) chk("B_lap_10_11", int'(wr_data), LAP_NB);
            if (wr_addr == 14'd0)   chk("B_lap_far", int'(wr_data), 0);
          end
          3: begin
            if (wr_addr == 14'd0)    chk("D_corner_after_rst", int'(wr_data), 9);
            if (wr_addr == 14'd2499) chk("D_corner_last", int'(wr_data), 9);
          end
          default: ;
        endcase
        n_acc++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        hold_a = wr_addr;
        hold_d = wr_data;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wait_acc(input int target, input string nm);
    int k;
    k = 0;
    while (n_acc < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_reached"}, int'(n_acc >= target), 1);
  endtask

  task automatic run_frame(input string nm, input int exp_cyc, input bit with_coef,
                           input int cidx, input int cval);
    int n;
    n = 0;
    @(posedge clk); #1;
    start = 1'b1;
    if (with_coef) begin
      coef_wr   = 1'b1;
      coef_idx  = 4'(cidx);
      coef_data = 8'(cval);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    coef_wr = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_after_start"}, int'(busy), 1);
    while (n < 40000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
    chk({nm, "_done_cycle"}, n, exp_cyc);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic load_coef(input int idx, input int val);
    @(posedge clk); #1;
    coef_wr   = 1'b1;
    coef_idx  = 4'(idx);
    coef_data = 8'(val);
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  // Frame A side activity: 5-cycle stall at pixel 7, busy kernel write, mid-frame start.
  task automatic disturb_a();
    int k;
    wait_acc(7, "A_px7");
    @(posedge clk); #1;
    wr_ready = 1'b0;
    k = 0;
    while (!wr_en && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("A_stall_wr_en_seen", int'(wr_en), 1);
    repeat (5) @(posedge clk);
    #1 wr_ready = 1'b1;
    wait_acc(20, "A_px20");
    load_coef(4, 0);
    wait_acc(200, "A_px200");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("A_busy_after_midstart", int'(busy), 1);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) img[i] = 8'd16;
    kern = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame A: default kernel, flat image 16.
    frame_id = 0;
    push_frame();
    fork
      run_frame("A", 27505, 1'b0, 0, 0);
      disturb_a();
    join
    chk("A_writes", n_acc, 2500);
    chk("A_queue_empty", q.size(), 0);
    chk("A_done_pulses", n_done, 1);

    // Frame B: Laplacian loaded in IDLE, last tap written together with start.
    frame_id = 1;
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    img[510] = 8'd255;
    kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    for (int i = 0; i < 8; i++) load_coef(i, kern[i]);
    load_coef(12, 7);
    push_frame();
    run_frame("B", 27500, 1'b1, 8, -1);
    chk("B_writes", n_acc, 5000);
    chk("B_queue_empty", q.size(), 0);
    chk("B_done_pulses", n_done, 2);

    // Frame C: aborted by reset at pixel 100.
    frame_id = 2;
    for (int i = 0; i < NPIX; i++) img[i] = 8'd16;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_acc(5100, "C_px100");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("C_rst_busy", int'(busy), 0);
    chk("C_rst_wr_en", int'(wr_en), 0);
    chk("C_rst_rd_en", int'(rd_en), 0);
    q.delete();
    repeat (5) @(negedge clk);
    chk("C_no_done", n_done, 2);

    // Frame D: kernel back to default after reset, restarts at address 0.
    frame_id = 3;
    kern = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    push_frame();
    run_frame("D", 27500, 1'b0, 0, 0);
    chk("D_writes", n_acc, 5100 + NPIX);
    chk("D_queue_empty", q.size(), 0);
    chk("D_done_pulses", n_done, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
